uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised rx, centre sampling, one-cycle rx_valid/frame_err pulses.
// rx_valid lands ~2+HALF+9*BAUD+1 clocks after the start edge; no backpressure, consumer must take it.
package uart_types;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_t;
endpackage

module uart_rx
  import uart_types::*;
#(
  parameter int CLK_FREQ  = 450_000_000,
  parameter int BAUD_RATE = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        frame_err,
  output uart_state_t rx_state
);

  localparam int BAUD_DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;
  localparam int CW           = $clog2(BAUD_DIVISOR);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIVISOR - 1);

  uart_state_t   state, state_nxt;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          stop_wait, wait_nxt;
  logic          shift_en, valid_nxt, ferr_nxt;
  logic          baud_done, half_done;

  // Synchroniser resets high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign baud_done = (cnt == BAUD_LAST);
  assign half_done = (cnt == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = stop_wait;
    shift_en  = 1'b0;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        wait_nxt = 1'b0;
        if (!rx_s) state_nxt = START_BIT;
      end
      START_BIT: begin
        if (half_done) state_nxt = rx_s ? IDLE : DATA_BITS;
      end
      DATA_BITS: begin
        if (baud_done) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP_BIT;
        end
      end
      STOP_BIT: begin
        // After a framing error, park here until the line is released so a break cannot re-trigger.
        if (stop_wait) begin
          if (rx_s) begin
            state_nxt = IDLE;
            wait_nxt  = 1'b0;
          end
        end else if (baud_done) begin
          if (rx_s) begin
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt = 1'b1;
            wait_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      stop_wait <= 1'b0;
    end else begin
      if ((state_nxt != state) || (state == IDLE) || shift_en)
        cnt <= '0;
      else if (!((state == STOP_BIT) && (stop_wait || ferr_nxt)))
        cnt <= cnt + 1'b1;

      if (state != DATA_BITS) bit_cnt <= 3'd0;
      else if (shift_en)      bit_cnt <= bit_cnt + 3'd1;

      if (shift_en)  shift_reg <= {rx_s, shift_reg[7:1]};
      if (valid_nxt) rx_data   <= shift_reg;

      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      stop_wait <= wait_nxt;
    end
  end

  assign rx_busy  = (state != IDLE);
  assign rx_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand-written corner sequences, randomized frames vs a byte-queue model.
module tb_uart_rx;
  import uart_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_busy;
  logic        frame_err;
  uart_state_t rx_state;

  uart_rx dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err), .rx_state(rx_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         c;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    int         div;
    bit         stop;
    int         hold;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  t_start = 0;
  int  ferr_cnt = 0;
  bit  prev_pulse = 1'b0;
  ev_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        ev_t e;
        e.d = rx_data;
        e.c = cyc;
        got_q.push_back(e);
      end
      if (frame_err) ferr_cnt++;
      if (rx_valid || frame_err) begin
        chk("pulse_exclusive", int'(rx_valid && frame_err), 0);
        chk("pulse_width", int'(prev_pulse), 0);
      end
      prev_pulse = rx_valid || frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input bit stop);
    t_start = cyc;
    rx = 1'b0;
    step(div);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(div);
    end
    rx = stop;
    step(div);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_rx_busy", int'(rx_busy), 0);
    chk("rst_state", int'(rx_state), int'(IDLE));
  endtask

  vec_t       vecs[5];
  int         b0, f0, ferr_exp;
  logic [7:0] d_prev;
  logic [7:0] rd;
  logic [7:0] exp_q[$];
  int         rdiv;
  bit         rstop;

  initial begin
    vecs[0] = '{8'hA5, 90, 1'b1, 0,    1, 0, 8'hA5};
    vecs[1] = '{8'hC3, 86, 1'b1, 0,    1, 0, 8'hC3};
    vecs[2] = '{8'hC3, 94, 1'b1, 0,    1, 0, 8'hC3};
    vecs[3] = '{8'h55, 90, 1'b0, 2000, 0, 1, 8'hC3};
    vecs[4] = '{8'h81, 90, 1'b1, 0,    1, 0, 8'h81};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    step(5);

    for (int i = 0; i < 5; i++) begin
      b0 = got_q.size();
      f0 = ferr_cnt;
      send_frame(vecs[i].d, vecs[i].div, vecs[i].stop);
      if (vecs[i].hold > 0) begin
        step(vecs[i].hold / 2);
        chk("break_holds_stop", int'(rx_state), int'(STOP_BIT));
        step(vecs[i].hold - vecs[i].hold / 2);
      end
      rx = 1'b1;
      step(30);
      chk("vec_valid_count", got_q.size() - b0, vecs[i].exp_valid);
      chk("vec_ferr_count", ferr_cnt - f0, vecs[i].exp_ferr);
      chk("vec_rx_data", int'(rx_data), int'(vecs[i].exp_data));
      if (vecs[i].exp_valid == 1 && got_q.size() > b0) begin
        chk("vec_pulse_data", int'(got_q[b0].d), int'(vecs[i].exp_data));
        if (vecs[i].div == 90)
          chk_rng("vec_latency", got_q[b0].c - t_start, 857, 859);
      end
    end

    // Back-to-back frames with zero idle, busy observed mid-frame.
    b0 = got_q.size();
    f0 = ferr_cnt;
    fork
      begin
        send_frame(8'h00, 90, 1'b1);
        send_frame(8'hFF, 90, 1'b1);
        send_frame(8'h3C, 90, 1'b1);
      end
      begin
        step(10);
        chk("busy_early", int'(rx_busy), 1);
        step(840);
        chk("busy_late", int'(rx_busy), 1);
      end
    join
    step(30);
    chk("b2b_busy_after", int'(rx_busy), 0);
    chk("b2b_count", got_q.size() - b0, 3);
    chk("b2b_ferr", ferr_cnt - f0, 0);
    if (got_q.size() - b0 == 3) begin
      chk("b2b_d0", int'(got_q[b0].d), 8'h00);
      chk("b2b_d1", int'(got_q[b0+1].d), 8'hFF);
      chk("b2b_d2", int'(got_q[b0+2].d), 8'h3C);
      chk("b2b_gap01", got_q[b0+1].c - got_q[b0].c, 900);
      chk("b2b_gap12", got_q[b0+2].c - got_q[b0+1].c, 900);
    end

    // 30-clock glitch on idle line.
    b0 = got_q.size();
    f0 = ferr_cnt;
    d_prev = rx_data;
    rx = 1'b0;
    step(30);
    rx = 1'b1;
    step(10);
    chk("glitch_in_start", int'(rx_state), int'(START_BIT));
    step(30);
    chk("glitch_back_idle", int'(rx_state), int'(IDLE));
    step(900);
    chk("glitch_no_valid", got_q.size() - b0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    chk("glitch_data_kept", int'(rx_data), int'(d_prev));

    // Randomized frames: good frames must appear in order, bad stops count as framing errors.
    b0 = got_q.size();
    f0 = ferr_cnt;
    ferr_exp = 0;
    for (int n = 0; n < 16; n++) begin
      rd    = 8'($urandom);
      rdiv  = int'($urandom_range(87, 93));
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rd, rdiv, rstop);
      if (!rstop) begin
        ferr_exp++;
        step(int'($urandom_range(0, 100)));
        rx = 1'b1;
        step(int'($urandom_range(5, 30)));
      end else begin
        exp_q.push_back(rd);
        step(int'($urandom_range(0, 3)));
      end
    end
    step(40);
    chk("rand_valid_count", got_q.size() - b0, exp_q.size());
    chk("rand_ferr_count", ferr_cnt - f0, ferr_exp);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b0 + i < got_q.size())
        chk("rand_data", int'(got_q[b0+i].d), int'(exp_q[i]));
    end

    // Reset during 4th data bit of 0x5A.
    rd = 8'h5A;
    rx = 1'b0;
    step(90);
    for (int i = 0; i < 3; i++) begin
      rx = rd[i];
      step(90);
    end
    rx = rd[3];
    step(40);
    rst_n = 1'b0;
    step(2);
    chk_reset_vals();
    rx = 1'b1;
    step(5);
    rst_n = 1'b1;
    b0 = got_q.size();
    f0 = ferr_cnt;
    step(1500);
    chk("abort_no_valid", got_q.size() - b0, 0);
    chk("abort_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h96, 90, 1'b1);
    step(30);
    chk("post_rst_count", got_q.size() - b0, 1);
    chk("post_rst_data", int'(rx_data), 8'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
